// File: rtl/ym3438_pg_pkg.sv
// Shared constants, types and helpers for the phase-generator frequency scheduler.
// Holds the slot/frequency widths, register addresses, the op order and the kcode rule.
package ym3438_pg_pkg;

    localparam int unsigned NUM_SLOTS   = 24;
    localparam int unsigned NUM_CH      = 6;
    localparam int unsigned FNUM_W      = 11;
    localparam int unsigned BLK_W       = 3;
    localparam int unsigned NUM_ENTRIES = 9;
    localparam int unsigned SLOT_W      = 5;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned KCODE_W     = 5;

    localparam logic [7:0] ADDR_FNUM_LO = 8'hA0;
    localparam logic [7:0] ADDR_FNUM_HI = 8'hA4;
    localparam logic [7:0] ADDR_CH3_LO  = 8'hA8;
    localparam logic [7:0] ADDR_CH3_HI  = 8'hAC;
    localparam logic [7:0] ADDR_MODE    = 8'h27;

    typedef enum logic [1:0] {
        OP1 = 2'd0,
        OP2 = 2'd1,
        OP3 = 2'd2,
        OP4 = 2'd3
    } op_e;

    // One stored frequency entry; bit layout matches {hi_latch[5:0], lo_byte[7:0]}.
    typedef struct packed {
        logic [BLK_W-1:0]  block;
        logic [FNUM_W-1:0] fnum;
    } freq_t;

    // Slot groups of six run in the order op1, op3, op2, op4.
    function automatic op_e op_of_group(input logic [1:0] grp);
        op_e op;
        case (grp)
            2'd0:    op = OP1;
            2'd1:    op = OP3;
            2'd2:    op = OP2;
            default: op = OP4;
        endcase
        return op;
    endfunction

    function automatic logic [KCODE_W-1:0] calc_kcode(input freq_t f);
        logic note;
        note = (f.fnum[10] & (|f.fnum[9:7])) | (~f.fnum[10] & (&f.fnum[9:7]));
        return {f.block, f.fnum[10], note};
    endfunction

endpackage

// File: rtl/ym3438_pg_freq_regfile.sv
// F-number/block storage: six channel entries plus three ch3 operator entries,
// the two shared high-byte latches, the 0x27 mode bits and the write decoder.
module ym3438_pg_freq_regfile
    import ym3438_pg_pkg::*;
(
    input  logic             MCLK,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [7:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output freq_t            rd_data,
    output logic [1:0]       ch3_mode
);

    freq_t      r_entry [NUM_ENTRIES];
    logic [5:0] r_fnum_hi;
    logic [5:0] r_ch3_hi;
    logic [1:0] r_ch3_mode;

    logic [1:0]       w_off;
    logic [7:0]       w_grp;
    logic             w_lo_sel;
    logic             w_hi_sel;
    logic             w_c3lo_sel;
    logic             w_c3hi_sel;
    logic             w_mode_sel;
    logic [IDX_W-1:0] w_lo_idx;
    logic [IDX_W-1:0] w_c3_idx;

    // Address groups of four; the fourth address of each group (A3/A7/AB/AF) is unused.
    assign w_off      = wr_addr[1:0];
    assign w_grp      = wr_addr & 8'hFC;
    assign w_lo_sel   = wr_en && (w_grp == ADDR_FNUM_LO) && (w_off != 2'd3);
    assign w_hi_sel   = wr_en && (w_grp == ADDR_FNUM_HI) && (w_off != 2'd3);
    assign w_c3lo_sel = wr_en && !wr_bank && (w_grp == ADDR_CH3_LO) && (w_off != 2'd3);
    assign w_c3hi_sel = wr_en && (w_grp == ADDR_CH3_HI) && (w_off != 2'd3);
    assign w_mode_sel = wr_en && !wr_bank && (wr_addr == ADDR_MODE);
    assign w_lo_idx   = IDX_W'(w_off) + (wr_bank ? IDX_W'(3) : IDX_W'(0));
    assign w_c3_idx   = IDX_W'(NUM_CH) + IDX_W'(w_off);

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_ENTRIES); i++) r_entry[i] <= '0;
            r_fnum_hi  <= '0;
            r_ch3_hi   <= '0;
            r_ch3_mode <= '0;
        end else begin
            if (w_hi_sel)   r_fnum_hi  <= wr_data[5:0];
            if (w_c3hi_sel) r_ch3_hi   <= wr_data[5:0];
            if (w_mode_sel) r_ch3_mode <= wr_data[7:6];
            // High latches are kept after commit so repeated low writes reuse them.
            if (w_lo_sel)   r_entry[w_lo_idx] <= freq_t'({r_fnum_hi, wr_data});
            if (w_c3lo_sel) r_entry[w_c3_idx] <= freq_t'({r_ch3_hi, wr_data});
        end
    end

    assign rd_data  = r_entry[rd_idx];
    assign ch3_mode = r_ch3_mode;

endmodule

// File: rtl/ym3438_pg_freq_sched.sv
// Slot scheduler in front of the phase generator: 24-slot TDM counter, ch/op decode,
// ch3 special-mode parameter select and registered fnum/block/kcode per slot.
module ym3438_pg_freq_sched
    import ym3438_pg_pkg::*;
(
    input  logic               MCLK,
    input  logic               reset,
    input  logic               slot_adv,
    input  logic               sync,
    input  logic               wr_en,
    input  logic               wr_bank,
    input  logic [7:0]         wr_addr,
    input  logic [7:0]         wr_data,
    output logic [SLOT_W-1:0]  slot,
    output logic [11:0]        fnum,
    output logic [BLK_W-1:0]   block,
    output logic [KCODE_W-1:0] kcode,
    output logic [1:0]         ch3_mode,
    output logic               slot_valid
);

    logic [SLOT_W-1:0]  r_slot;
    logic [11:0]        r_fnum;
    logic [BLK_W-1:0]   r_block;
    logic [KCODE_W-1:0] r_kcode;
    logic               r_slot_valid;

    logic [SLOT_W-1:0]  w_next_slot;
    logic [2:0]         w_ch;
    logic [1:0]         w_group;
    op_e                w_op;
    logic               w_special;
    logic [IDX_W-1:0]   w_rd_idx;
    freq_t              w_rd;
    logic [1:0]         w_ch3_mode;

    ym3438_pg_freq_regfile u_regfile (
        .MCLK     (MCLK),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_bank  (wr_bank),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_idx   (w_rd_idx),
        .rd_data  (w_rd),
        .ch3_mode (w_ch3_mode)
    );

    assign w_next_slot = (sync || (r_slot == SLOT_W'(NUM_SLOTS - 1))) ? '0 : r_slot + SLOT_W'(1);
    assign w_ch        = 3'(w_next_slot % SLOT_W'(NUM_CH));
    assign w_group     = 2'(w_next_slot / SLOT_W'(NUM_CH));
    assign w_op        = op_of_group(w_group);
    assign w_special   = (w_ch == 3'd2) && (w_ch3_mode != 2'd0) && (w_op != OP4);

    // Special-mode ch3 entries sit after the six channels in A8, A9, AA order (op3, op1, op2).
    always_comb begin
        w_rd_idx = IDX_W'(w_ch);
        if (w_special) begin
            case (w_op)
                OP1:     w_rd_idx = IDX_W'(NUM_CH + 1);
                OP2:     w_rd_idx = IDX_W'(NUM_CH + 2);
                default: w_rd_idx = IDX_W'(NUM_CH);
            endcase
        end
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            r_slot       <= '0;
            r_fnum       <= '0;
            r_block      <= '0;
            r_kcode      <= '0;
            r_slot_valid <= 1'b0;
        end else begin
            r_slot_valid <= slot_adv;
            if (slot_adv) begin
                r_slot  <= w_next_slot;
                r_fnum  <= 12'(w_rd.fnum);
                r_block <= w_rd.block;
                r_kcode <= calc_kcode(w_rd);
            end
        end
    end

    assign slot       = r_slot;
    assign fnum       = r_fnum;
    assign block      = r_block;
    assign kcode      = r_kcode;
    assign ch3_mode   = w_ch3_mode;
    assign slot_valid = r_slot_valid;

endmodule

// File: tb/tb_ym3438_pg_freq_sched.sv
// Scoreboard bench for ym3438_pg_freq_sched: stimulus pushes hand-computed per-slot
// expectations, a negedge monitor pops and compares whenever slot_valid is high.
module tb_ym3438_pg_freq_sched;

    logic        MCLK = 1'b0;
    logic        reset;
    logic        slot_adv;
    logic        sync;
    logic        wr_en;
    logic        wr_bank;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  slot;
    logic [11:0] fnum;
    logic [2:0]  block;
    logic [4:0]  kcode;
    logic [1:0]  ch3_mode;
    logic        slot_valid;

    ym3438_pg_freq_sched dut (
        .MCLK       (MCLK),
        .reset      (reset),
        .slot_adv   (slot_adv),
        .sync       (sync),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .slot       (slot),
        .fnum       (fnum),
        .block      (block),
        .kcode      (kcode),
        .ch3_mode   (ch3_mode),
        .slot_valid (slot_valid)
    );

    always #5 MCLK = ~MCLK;

    typedef struct packed {
        logic [4:0]  slot;
        logic [11:0] fnum;
        logic [2:0]  blk;
        logic [4:0]  kc;
    } exp_t;

    exp_t        sb_q[$];
    logic [11:0] t_fnum [24];
    logic [2:0]  t_blk  [24];
    logic [4:0]  t_kc   [24];
    int          exp_slot;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry per slot_valid cycle.
    always @(negedge MCLK) begin
        if (!reset && slot_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_slot_valid", 32'(slot_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("slot",  32'(slot),  32'(e.slot));
                check("fnum",  32'(fnum),  32'(e.fnum));
                check("block", 32'(block), 32'(e.blk));
                check("kcode", 32'(kcode), 32'(e.kc));
            end
        end
    end

    task automatic clear_table();
        for (int i = 0; i < 24; i++) begin
            t_fnum[i] = '0; t_blk[i] = '0; t_kc[i] = '0;
        end
    endtask

    task automatic set_slot(input int s, input logic [11:0] f, input logic [2:0] b, input logic [4:0] k);
        t_fnum[s] = f; t_blk[s] = b; t_kc[s] = k;
    endtask

    // Channel index 0..5 occupies slots ch, ch+6, ch+12, ch+18.
    task automatic set_ch(input int ch, input logic [11:0] f, input logic [2:0] b, input logic [4:0] k);
        for (int g = 0; g < 4; g++) set_slot(ch + 6 * g, f, b, k);
    endtask

    // One MCLK of stimulus; called and returning at posedge+1.
    task automatic step(input logic adv, input logic syn, input logic we,
                        input logic bank, input logic [7:0] addr, input logic [7:0] data);
        slot_adv = adv; sync = syn; wr_en = we; wr_bank = bank; wr_addr = addr; wr_data = data;
        if (adv) begin
            exp_slot = (syn || exp_slot == 23) ? 0 : exp_slot + 1;
            sb_q.push_back({5'(exp_slot), t_fnum[exp_slot], t_blk[exp_slot], t_kc[exp_slot]});
        end
        @(posedge MCLK);
        #1;
        slot_adv = 1'b0; sync = 1'b0; wr_en = 1'b0; wr_bank = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic adv(input logic syn);
        step(1'b1, syn, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic wr(input logic bank, input logic [7:0] addr, input logic [7:0] data);
        step(1'b0, 1'b0, 1'b1, bank, addr, data);
    endtask

    task automatic frame();
        adv(1'b1);
        for (int i = 0; i < 23; i++) adv(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; slot_adv = 1'b0; sync = 1'b0; wr_en = 1'b0;
        wr_bank = 1'b0; wr_addr = '0; wr_data = '0;
        exp_slot = 0;
        clear_table();
        repeat (3) @(posedge MCLK);
        #1;
        check("rst_slot",       32'(slot),       32'd0);
        check("rst_fnum",       32'(fnum),       32'd0);
        check("rst_block",      32'(block),      32'd0);
        check("rst_kcode",      32'(kcode),      32'd0);
        check("rst_ch3_mode",   32'(ch3_mode),   32'd0);
        check("rst_slot_valid", 32'(slot_valid), 32'd0);
        reset = 1'b0;
        @(posedge MCLK); #1;

        // 30 advances from sync: 0..23 then wrap to 0..5, all zero parameters.
        adv(1'b1);
        for (int i = 0; i < 29; i++) adv(1'b0);

        // ch1: block 4, fnum 0x269 -> kcode {100,0,0}.
        wr(1'b0, 8'hA4, 8'h22);
        wr(1'b0, 8'hA0, 8'h69);
        set_ch(0, 12'h269, 3'd4, 5'h10);
        frame();

        // ch5 via bank 1: block 3, fnum 0x4FF -> kcode {011,1,1}.
        wr(1'b1, 8'hA5, 8'h1C);
        wr(1'b1, 8'hA1, 8'hFF);
        set_ch(4, 12'h4FF, 3'd3, 5'h0F);
        frame();

        // ch3 special mode.
        wr(1'b0, 8'h27, 8'h40);
        wr(1'b0, 8'hAD, 8'h0A);
        wr(1'b0, 8'hA9, 8'h55);
        wr(1'b0, 8'hAC, 8'h05);
        wr(1'b0, 8'hA8, 8'h11);
        wr(1'b0, 8'hA6, 8'h03);
        wr(1'b0, 8'hA2, 8'h33);
        check("ch3_mode_on", 32'(ch3_mode), 32'd1);
        set_slot(2,  12'h255, 3'd1, 5'h04);
        set_slot(8,  12'h511, 3'd0, 5'h03);
        set_slot(14, 12'h000, 3'd0, 5'h00);
        set_slot(20, 12'h333, 3'd0, 5'h00);
        frame();

        // Ignored writes: bank-1 0x27/A8, unused A3/A7/AB/AF.
        wr(1'b1, 8'h27, 8'hC0);
        wr(1'b1, 8'hA8, 8'h77);
        wr(1'b0, 8'hA3, 8'h5A);
        wr(1'b0, 8'hAB, 8'h5A);
        wr(1'b0, 8'hAF, 8'h3F);
        check("ch3_mode_bank1_ignored", 32'(ch3_mode), 32'd1);
        frame();

        wr(1'b0, 8'h27, 8'h00);
        check("ch3_mode_off", 32'(ch3_mode), 32'd0);
        set_ch(2, 12'h333, 3'd0, 5'h00);
        frame();

        // Write coinciding with the advance into slot 0: old value now, new one next frame.
        wr(1'b0, 8'hA4, 8'h22);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'hA0, 8'h77);
        set_ch(0, 12'h277, 3'd4, 5'h10);
        for (int i = 0; i < 24; i++) adv(1'b0);

        // Latch reuse across two low-byte commits.
        wr(1'b0, 8'hA4, 8'h15);
        wr(1'b0, 8'hA0, 8'h01);
        wr(1'b0, 8'hA1, 8'h02);
        set_ch(0, 12'h501, 3'd2, 5'h0B);
        set_ch(1, 12'h502, 3'd2, 5'h0B);
        frame();

        // sync without slot_adv must not move the counter.
        adv(1'b1); adv(1'b0); adv(1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        check("sync_alone_hold", 32'(slot), 32'd2);
        adv(1'b0); adv(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Asynchronous reset mid-frame clears outputs in the same cycle.
        #2;
        reset = 1'b1;
        #1;
        check("midrst_slot",       32'(slot),       32'd0);
        check("midrst_fnum",       32'(fnum),       32'd0);
        check("midrst_block",      32'(block),      32'd0);
        check("midrst_kcode",      32'(kcode),      32'd0);
        check("midrst_slot_valid", 32'(slot_valid), 32'd0);
        @(posedge MCLK); #1;
        reset = 1'b0;
        clear_table();
        exp_slot = 0;
        adv(1'b0);
        adv(1'b0);
        adv(1'b0);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge MCLK);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
